seq_detector_mealy_param: RTL and testbench
===========================================

# seq_detector_mealy_param

Parametrised, runtime-programmable Mealy serial-pattern detector. It is the successor to the fixed 4-bit "1011" detector. It has these features:
- pattern up to MAX_LEN bits, loadable at run time;
- selectable overlapping or non-overlapping match mode;
- input-valid qualifier;
- saturating match counter.

It sits on a serial bit stream and flags the cycle in which the final pattern bit arrives.

## Interface
- MAX_LEN, 16: maximum pattern length in bits; legal range 2..32.
- CNT_W, 8: width of the match counter.
- LEN_W, $clog2(MAX_LEN+1): width of the length field. Derived; do not override.
- clk  in  1  single clock; everything is sampled on the rising edge.
- reset  in  1  asynchronous, active-low; 0 resets all state immediately.
- din  in  1  serial data bit.
- din_valid  in  1  qualifies din; when low, the bit is ignored and no state changes.
- pat_load  in  1  one-cycle strobe that loads pat_in, pat_len_in and mode_in.
- pat_in  in  MAX_LEN  new pattern, right-aligned; bit 0 is the last bit received.
- pat_len_in  in  LEN_W  new pattern length.
- mode_in  in  1  0 = overlapping, 1 = non-overlapping.
- detected  out  1  Mealy match flag; combinational from din/din_valid.
- match_count  out  CNT_W  registered count of matches, saturating.
- busy  out  1  high once the history holds at least pat_len-1 valid bits.

## Operation
- Registers:
  - pattern (MAX_LEN)
  - pat_len (LEN_W)
  - mode
  - hist, shift register of past bits (MAX_LEN-1)
  - fill, count of valid bits in hist, saturating at MAX_LEN-1
  - match_count
- Reset values:
  - pattern = 'b1011 (zero-extended); pat_len = 4; mode = overlapping;
  - hist = 0; fill = 0; match_count = 0;
  - detected = 0 while reset is low; busy = 0.
- Window: cand = {hist[pat_len-2:0], din}.
- Match condition: detected = din_valid & !pat_load & (fill >= pat_len-1) & (cand == pattern[pat_len-1:0]).
  - Pattern bits at or above pat_len are ignored.
- Update when din_valid is high and pat_load is low:
  - hist <= {hist, din}; fill <= min(fill+1, MAX_LEN-1).
  - If detected: match_count increments, holding at 2^CNT_W-1.
  - If detected and mode is non-overlapping: fill <= 0, so the next match needs a full fresh pat_len bits. hist still shifts.
- Length clamping:
  - pat_len_in of 0 or 1 → pat_len = 1; no history is needed and every matching valid bit detects.
  - pat_len_in > MAX_LEN → clamped to MAX_LEN.
- pat_load:
  - Captures pattern, clamped length and mode.
  - Clears fill and match_count.
  - Has priority over din_valid in the same cycle: that din bit is discarded and detected = 0.
- Reset asserted mid-stream: all state returns to the reset values asynchronously. A partial match in progress is lost.
- Internal states (implicit in fill):
  - FILLING: fill < pat_len-1.
  - ARMED: fill >= pat_len-1; busy = 1.
  - Transition ARMED→FILLING happens on pat_load, on reset, or on a non-overlapping match (only if pat_len > 1).

## Timing
- detected is a Mealy output: asserted in the same cycle that the final bit is presented with din_valid high, before the clock edge. It must be sampled before that edge.
- Zero-cycle latency from the last pattern bit to detected.
- match_count reflects a match one cycle later, after the edge.
- busy is registered (derived from fill).
- The first detection is possible on the pat_len-th valid bit after reset or pat_load.
- Gaps with din_valid low do not break a partial match.
- No combinational path from pat_in or pat_len_in to detected. pat_load does reach detected combinationally (it masks it).

## Structure
- Package seq_det_pkg contains:
  - typedef enum logic {MODE_OVERLAP=0, MODE_NONOVERLAP=1} seq_mode_t;
  - localparam DEFAULT_PAT = 'b1011 and DEFAULT_LEN = 4;
  - a function clamp_len(len, max).
- One sub-module, seq_det_match: purely combinational masked comparator.
  - Inputs: hist, din, pattern, pat_len, fill.
  - Output: hit.
  - Parametrised on MAX_LEN.
- Top level holds the registers, fill/counter logic and load priority.

## Test plan
- Reset defaults; stream 1,0,1,1 with din_valid=1 → detected=1 only on the 4th bit; match_count=1 on the next cycle.
- Overlap mode, default pattern; stream 1,0,1,1,0,1,1 → detected on bits 4 and 7; match_count=2.
- Load pat_in='b1010, length 4, non-overlapping; stream 1,0,1,0,1,0 → detected on bit 4 only.
  - Then stream 1,0 further → detected on bit 8; match_count=2.
- Length 16, pattern 'hA5C3, bits with din_valid toggling low every other cycle → a single detection on the 16th valid bit; no detection while din_valid is low.
- pat_load asserted in the same cycle as the completing bit → detected=0, match_count=0, fill=0.
  - pat_len_in=0 → behaves as length 1: each matching valid bit detects.
- Reset driven low mid-pattern after 1,0,1 and released, then 1 → no detection.
  - Saturation: CNT_W=2 with five matches → match_count stays at 3.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
// The length clamp is shared so load logic and any user agree on limits.
package seq_det_pkg;

  typedef enum logic {
    MODE_OVERLAP    = 1'b0,
    MODE_NONOVERLAP = 1'b1
  } seq_mode_t;

  localparam int unsigned DEFAULT_PAT = 32'b1011;
  localparam int unsigned DEFAULT_LEN = 4;

  function automatic int unsigned clamp_len(
    input int unsigned len,
    input int unsigned max_len
  );
    if (len <= 1) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/seq_det_match.sv
// Masked comparator: history plus the live bit against the low pat_len
// pattern bits, qualified by enough valid history.
module seq_det_match #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-2:0] hist_i,
  input  logic               din_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   pat_len_i,
  input  logic [LEN_W-1:0]   fill_i,
  output logic               hit_o
);

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic               armed;

  always_comb begin
    cand = {hist_i, din_i};
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = LEN_W'(i) < pat_len_i;
    end
    // fill >= pat_len-1 without underflow
    armed = ({1'b0, fill_i} + 1'b1) >= {1'b0, pat_len_i};
    hit_o = armed && (((cand ^ pattern_i) & mask) == '0);
  end

endmodule

// File: rtl/seq_detector_mealy_param.sv
// Runtime-programmable Mealy serial pattern detector with overlap control,
// input qualifier and saturating match counter.
module seq_detector_mealy_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   pat_len_in,
  input  logic               mode_in,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy
);

  localparam int HW = MAX_LEN - 1;

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   pat_len_q, pat_len_d;
  seq_mode_t          mode_q, mode_d;
  logic [HW-1:0]      hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hit;

  seq_det_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_match (
    .hist_i    (hist_q),
    .din_i     (din),
    .pattern_i (pattern_q),
    .pat_len_i (pat_len_q),
    .fill_i    (fill_q),
    .hit_o     (hit)
  );

  assign detected    = din_valid & ~pat_load & hit;
  assign match_count = cnt_q;
  assign busy = ({1'b0, fill_q} + 1'b1) >= {1'b0, pat_len_q};

  always_comb begin
    pattern_d = pattern_q;
    pat_len_d = pat_len_q;
    mode_d    = mode_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    if (pat_load) begin
      pattern_d = pat_in;
      pat_len_d = LEN_W'(clamp_len(32'(pat_len_in), MAX_LEN));
      mode_d    = seq_mode_t'(mode_in);
      fill_d    = '0;
      cnt_d     = '0;
    end else if (din_valid) begin
      hist_d = HW'({hist_q, din});
      if (fill_q != LEN_W'(HW)) fill_d = fill_q + 1'b1;
      if (detected) begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        // next match must be built from fresh bits
        if (mode_q == MODE_NONOVERLAP) fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q <= MAX_LEN'(DEFAULT_PAT);
      pat_len_q <= LEN_W'(DEFAULT_LEN);
      mode_q    <= MODE_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      pat_len_q <= pat_len_d;
      mode_q    <= mode_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_detector_mealy_param.sv
// Scoreboard bench: a bit-history reference model predicts each cycle,
// a monitor compares two detector instances (wide and 2-bit counters).
module tb_seq_detector_mealy_param;

  localparam int ML = 16;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          din;
  logic          din_valid;
  logic          pat_load;
  logic [ML-1:0] pat_in;
  logic [LW-1:0] pat_len_in;
  logic          mode_in;

  logic          det8, busy8;
  logic [7:0]    cnt8;
  logic          det2, busy2;
  logic [1:0]    cnt2;

  always #5 clk = ~clk;

  seq_detector_mealy_param #(
    .MAX_LEN (ML),
    .CNT_W   (8)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .pat_len_in  (pat_len_in),
    .mode_in     (mode_in),
    .detected    (det8),
    .match_count (cnt8),
    .busy        (busy8)
  );

  seq_detector_mealy_param #(
    .MAX_LEN (ML),
    .CNT_W   (2)
  ) u_sat (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .pat_len_in  (pat_len_in),
    .mode_in     (mode_in),
    .detected    (det2),
    .match_count (cnt2),
    .busy        (busy2)
  );

  typedef struct {
    bit det;
    int cnt;
    bit busy;
  } exp_t;

  exp_t sb[$];

  // reference state: every valid bit since reset, and bits since last clear
  bit          hq[$];
  int          since;
  int          len;
  int          cnt;
  bit          nonov;
  logic [15:0] pat;

  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    hq.delete();
    since = 0;
    len   = 4;
    cnt   = 0;
    nonov = 1'b0;
    pat   = 16'hB;
  endtask

  function automatic bit tail_matches(input bit d);
    if (pat[0] != d) return 1'b0;
    for (int i = 1; i < len; i++) begin
      if (hq[hq.size() - i] != pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic step(
    input bit          r,
    input bit          v,
    input bit          d,
    input bit          ld,
    input logic [15:0] p,
    input int          l,
    input bit          m
  );
    exp_t e;
    @(negedge clk);
    reset      = r;
    din_valid  = v;
    din        = d;
    pat_load   = ld;
    pat_in     = p;
    pat_len_in = LW'(l);
    mode_in    = m;
    e.det = 1'b0;
    if (!r) begin
      model_reset();
    end else if (ld) begin
      pat   = p;
      len   = (l <= 1) ? 1 : ((l > ML) ? ML : l);
      nonov = m;
      since = 0;
      cnt   = 0;
    end else if (v) begin
      e.det = (since >= len - 1) && tail_matches(d);
      hq.push_back(d);
      since++;
      if (e.det) begin
        cnt++;
        if (nonov) since = 0;
      end
    end
    e.cnt  = cnt;
    e.busy = since >= len - 1;
    sb.push_back(e);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'($urandom), 1'b0, 16'h0, 0, 1'b0);
  endtask

  task automatic rst_cycle();
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 0, 1'b0);
  endtask

  task automatic load(input logic [15:0] p, input int l, input bit m);
    step(1'b1, 1'($urandom), 1'($urandom), 1'b1, p, l, m);
  endtask

  task automatic bits(input logic [31:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, 1'b1, b[i], 1'b0, 16'h0, 0, 1'b0);
    end
  endtask

  task automatic chk(
    input string       n,
    input logic [31:0] a,
    input logic [31:0] x
  );
    if (a !== x) begin
      miscompares++;
      $display("FAIL %s vec=%0d got=%0h want=%0h t=%0t",
               n, vectors, a, x, $time);
    end
  endtask

  exp_t me;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() != 0) begin
        me = sb.pop_front();
        vectors++;
        chk("det8", 32'(det8), 32'(me.det));
        chk("det2", 32'(det2), 32'(me.det));
        @(posedge clk);
        #1;
        chk("cnt8", 32'(cnt8), 32'(sat(me.cnt, 255)));
        chk("cnt2", 32'(cnt2), 32'(sat(me.cnt, 3)));
        chk("busy8", 32'(busy8), 32'(me.busy));
        chk("busy2", 32'(busy2), 32'(me.busy));
      end
    end
  end

  initial begin
    reset      = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    pat_load   = 1'b0;
    pat_in     = '0;
    pat_len_in = '0;
    mode_in    = 1'b0;
    model_reset();

    rst_cycle();
    rst_cycle();
    bits(32'b1011, 4);
    idle();

    rst_cycle();
    bits(32'b1011011, 7);
    idle();

    load(16'h000A, 4, 1'b1);
    bits(32'b10101010, 8);
    idle();

    load(16'hA5C3, 16, 1'b0);
    for (int i = 15; i >= 0; i--) begin
      step(1'b1, 1'b1, pat[i], 1'b0, 16'h0, 0, 1'b0);
      idle();
    end

    load(16'h000B, 4, 1'b0);
    bits(32'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h000B, 4, 1'b0);
    idle();

    load(16'hFFF1, 0, 1'b0);
    bits(32'b11010111, 8);

    rst_cycle();
    bits(32'b101, 3);
    rst_cycle();
    bits(32'b1, 1);
    idle();

    load(16'h0001, 1, 1'b0);
    bits(32'b111111, 6);
    load(16'hFFFF, 31, 1'b1);
    bits(32'hFFFF, 16);
    bits(32'hFFFF, 16);

    for (int r = 0; r < 40; r++) begin
      load(16'($urandom),
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20)
                                       : $urandom_range(1, 5),
           1'($urandom));
      for (int k = 0; k < 60; k++) begin
        if ($urandom_range(0, 99) == 0) begin
          rst_cycle();
        end else if ($urandom_range(0, 59) == 0) begin
          load(16'($urandom), $urandom_range(0, 6), 1'($urandom));
        end else begin
          step(1'b1, $urandom_range(0, 3) != 0, 1'($urandom),
               1'b0, 16'h0, 0, 1'b0);
        end
      end
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
